// File: rtl/round_robin_arbiter_n_req.sv
// N-requester round-robin arbiter with registered one-hot grants.
// The owner keeps the grant for up to MAX_BURST consecutive cycles while it requests.
module round_robin_arbiter_n_req #(
    parameter int N = 4,
    parameter int MAX_BURST = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX_RST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] burst_cnt;

    logic [N-1:0]     grants_d;
    logic             grant_valid_d;
    logic [IDX_W-1:0] grant_idx_d;
    logic [IDX_W-1:0] last_idx_d;
    logic [CNT_W-1:0] burst_cnt_d;

    logic             keep;
    logic             found;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;

    // Search starts one past the last owner and ends on the last owner itself,
    // so a sole requester at its burst limit is re-granted without a bubble.
    always_comb begin
        found   = 1'b0;
        win_idx = last_idx;
        cand    = last_idx;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IDX_MAX) ? '0 : cand + IDX_W'(1);
            if (!found && requests[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign keep = grant_valid && requests[grant_idx] && (burst_cnt < CNT_W'(MAX_BURST));

    always_comb begin
        grants_d      = grants;
        grant_valid_d = grant_valid;
        grant_idx_d   = grant_idx;
        last_idx_d    = last_idx;
        burst_cnt_d   = burst_cnt;
        if (!found) begin
            grants_d      = '0;
            grant_valid_d = 1'b0;
            burst_cnt_d   = '0;
        end else if (keep) begin
            burst_cnt_d = burst_cnt + CNT_W'(1);
        end else begin
            grants_d          = '0;
            grants_d[win_idx] = 1'b1;
            grant_valid_d     = 1'b1;
            grant_idx_d       = win_idx;
            last_idx_d        = win_idx;
            burst_cnt_d       = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_idx    <= LAST_IDX_RST;
            burst_cnt   <= '0;
        end else begin
            grants      <= grants_d;
            grant_valid <= grant_valid_d;
            grant_idx   <= grant_idx_d;
            last_idx    <= last_idx_d;
            burst_cnt   <= burst_cnt_d;
        end
    end

endmodule
